ccd_line_framer: RTL and testbench

- Write-side producer for the CCD readout async FIFO; sits directly upstream of the FIFO write-pointer/full logic in the ADC clock domain.
- Takes raw ADC pixel samples plus line/frame strobes and emits a framed word stream per line: SYNC, line number, pixels, trailer.
- Absorbs header insertion and FIFO backpressure in a small internal show-ahead buffer.
- Drives winc/wdata, honours wfull, and reports any data it had to drop.

---
 rtl/ccd_line_framer.sv | 150 +++++++++++++++
 tb/tb_ccd_line_framer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ccd_line_framer.sv
// CCD line framer: turns ADC pixel/strobe traffic into SYNC/line/pixels/trailer
// words and feeds them into the async FIFO write side through a small show-ahead buffer.
module ccd_line_framer #(
    parameter int                DATA_W    = 16,
    parameter int                LINE_W    = 12,
    parameter int                BUF_DEPTH = 8,
    parameter logic [DATA_W-1:0] SYNC      = {DATA_W{1'b1}}
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              line_end,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              ovf_clr,
    input  logic              wfull,
    output logic              winc,
    output logic [DATA_W-1:0] wdata,
    output logic              ovf,
    output logic [15:0]       drop_cnt,
    output logic [LINE_W-1:0] line_cnt,
    output logic              busy
);
    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, PIX} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [BUF_DEPTH];
    logic [AW:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic [DATA_W-2:0]   pix_cnt_q, pix_cnt_d;
    logic                line_ovf_q, line_ovf_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic                push, pix_store, trailer, abort;
    logic [DATA_W-1:0]   push_data;
    logic                empty, full, pop, push_ok, pix_drop, buf_drop;
    logic [16:0]         drop_sum;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign winc  = ~empty & ~wfull & ~wrst;
    assign pop   = winc;
    assign wdata = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push_ok  = push & (~full | pop);
    assign buf_drop = push & ~push_ok;
    assign pix_drop = pix_valid & ~pix_store;

    always_ff @(posedge wclk) begin
        if (wrst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (line_start) state_d = HDR;
        else begin
            case (state_q)
                HDR:     state_d = PIX;
                PIX:     if (line_end) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        push      = 1'b0;
        push_data = SYNC;
        pix_store = 1'b0;
        trailer   = 1'b0;
        abort     = 1'b0;
        if (line_start) begin
            push  = 1'b1;
            abort = (state_q == PIX);
        end else begin
            case (state_q)
                HDR: begin
                    push      = 1'b1;
                    push_data = DATA_W'(line_cnt_q);
                end
                PIX: begin
                    if (line_end) begin
                        push      = 1'b1;
                        trailer   = 1'b1;
                        push_data = {line_ovf_q, pix_cnt_q};
                    end else if (pix_valid) begin
                        push      = 1'b1;
                        pix_store = 1'b1;
                        // Pixels may never alias the sync word.
                        push_data = (pix_data >= SYNC) ? SYNC - DATA_W'(1) : pix_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wptr_d     = wptr_q + (AW+1)'(push_ok);
        rptr_d     = rptr_q + (AW+1)'(pop);
        line_cnt_d = line_cnt_q;
        if (frame_start)           line_cnt_d = '0;
        else if (abort || trailer) line_cnt_d = line_cnt_q + LINE_W'(1);
        pix_cnt_d = pix_cnt_q;
        if (line_start) pix_cnt_d = '0;
        else if (pix_store && push_ok && (pix_cnt_q != '1)) pix_cnt_d = pix_cnt_q + (DATA_W-1)'(1);
        line_ovf_d = line_ovf_q;
        if (pix_drop || buf_drop) line_ovf_d = 1'b1;
        else if (line_start)      line_ovf_d = 1'b0;
        ovf_d = ovf_q;
        if (pix_drop || buf_drop || abort) ovf_d = 1'b1;
        else if (ovf_clr)                  ovf_d = 1'b0;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(pix_drop) + 17'(buf_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            line_cnt_q <= '0;
            pix_cnt_q  <= '0;
            line_ovf_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            line_cnt_q <= line_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            line_ovf_q <= line_ovf_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst && push_ok) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;
    assign line_cnt = line_cnt_q;
    assign busy     = (state_q != IDLE) | ~empty;
endmodule

// File: tb/tb_ccd_line_framer.sv
// Directed bench for ccd_line_framer: expected FIFO words are queued as stimulus
// is driven and popped/compared whenever the DUT asserts winc.
module tb_ccd_line_framer;
    logic        wclk = 1'b0;
    logic        wrst, frame_start, line_start, line_end, pix_valid, ovf_clr, wfull;
    logic [15:0] pix_data;
    logic        winc, ovf, busy;
    logic [15:0] wdata, drop_cnt;
    logic [11:0] line_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    ccd_line_framer #(.DATA_W(16), .LINE_W(12), .BUF_DEPTH(8), .SYNC(16'hFFFF)) dut (
        .wclk(wclk), .wrst(wrst), .frame_start(frame_start), .line_start(line_start),
        .line_end(line_end), .pix_valid(pix_valid), .pix_data(pix_data), .ovf_clr(ovf_clr),
        .wfull(wfull), .winc(winc), .wdata(wdata), .ovf(ovf), .drop_cnt(drop_cnt),
        .line_cnt(line_cnt), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-side monitor: every FIFO write must match the scoreboard head.
    always @(negedge wclk) begin
        if (wfull === 1'b1) chk("winc_while_full", 32'(winc), 32'd0);
        if (winc === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_write", 32'(exp_q.size()), 32'd1);
            else                   chk("wdata", 32'(wdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge wclk); #1;
    endtask

    task automatic start_line(input logic [15:0] hdr);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(hdr);
        line_start = 1'b1; tick(); line_start = 1'b0; tick();
    endtask

    task automatic pixel(input logic [15:0] d, input logic [15:0] e, input bit stored);
        if (stored) exp_q.push_back(e);
        pix_valid = 1'b1; pix_data = d; tick(); pix_valid = 1'b0;
    endtask

    task automatic end_line(input logic [15:0] t, input bit stored);
        if (stored) exp_q.push_back(t);
        line_end = 1'b1; tick(); line_end = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin tick(); n++; end
        chk("drain_done", 32'(n < 200), 32'd1);
    endtask

    initial begin
        wrst = 1'b1; frame_start = 0; line_start = 0; line_end = 0;
        pix_valid = 0; pix_data = '0; ovf_clr = 0; wfull = 0;
        tick(); chk("winc_in_reset", 32'(winc), 0);
        tick(); wrst = 1'b0;
        chk("rst_winc", 32'(winc), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_line", 32'(line_cnt), 0);
        chk("rst_busy", 32'(busy), 0);

        // Basic line
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        start_line(16'h0000); tick();
        pixel(16'h0010, 16'h0010, 1); pixel(16'h0020, 16'h0020, 1); pixel(16'h0030, 16'h0030, 1);
        end_line(16'h0003, 1);
        drain();
        chk("basic_line_cnt", 32'(line_cnt), 1);
        chk("basic_ovf", 32'(ovf), 0);
        chk("basic_busy", 32'(busy), 0);

        // Pixel clamp below SYNC
        start_line(16'h0001);
        pixel(16'hFFFF, 16'hFFFE, 1); pixel(16'hFFFE, 16'hFFFE, 1);
        end_line(16'h0002, 1);
        drain();
        chk("sat_line_cnt", 32'(line_cnt), 2);

        // Walk line_cnt up to 4095, then wrap
        for (int n = 2; n < 4095; n++) begin
            start_line(16'(n));
            end_line(16'h0000, 1);
        end
        drain();
        chk("wrap_pre", 32'(line_cnt), 4095);
        start_line(16'h0FFF);
        pixel(16'h1234, 16'h1234, 1);
        end_line(16'h0001, 1);
        drain();
        chk("wrap_post", 32'(line_cnt), 0);
        chk("wrap_ovf", 32'(ovf), 0);

        // Backpressure: 7 words, 5 cycles of wfull, nothing lost
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wfull = 1'b1;
        start_line(16'h0000);
        pixel(16'h0A01, 16'h0A01, 1); pixel(16'h0A02, 16'h0A02, 1); pixel(16'h0A03, 16'h0A03, 1);
        chk("bp_held", 32'(exp_q.size()), 5);
        wfull = 1'b0;
        pixel(16'h0A04, 16'h0A04, 1);
        end_line(16'h0004, 1);
        drain();
        chk("bp_ovf", 32'(ovf), 0);
        chk("bp_drop", 32'(drop_cnt), 0);

        // Overflow: 13 words into an 8-entry buffer with the FIFO full
        wfull = 1'b1;
        start_line(16'h0001);
        for (int i = 0; i < 10; i++) pixel(16'(16'h0100 + i), 16'(16'h0100 + i), i < 6);
        end_line(16'h0000, 0);
        chk("ovf_drop", 32'(drop_cnt), 5);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_line_cnt", 32'(line_cnt), 2);
        wfull = 1'b0;
        drain();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);
        chk("ovf_drop_hold", 32'(drop_cnt), 5);

        // Pixel during HDR is dropped; second line_start aborts the line
        exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0002);
        line_start = 1'b1; tick(); line_start = 1'b0;
        pix_valid = 1'b1; pix_data = 16'h0055; tick(); pix_valid = 1'b0;
        chk("hdr_pix_drop", 32'(drop_cnt), 6);
        ovf_clr = 1'b1;
        pixel(16'h0040, 16'h0040, 1);
        ovf_clr = 1'b0;
        chk("pre_abort_ovf", 32'(ovf), 0);
        start_line(16'h0003);
        chk("abort_ovf", 32'(ovf), 1);
        chk("abort_line_cnt", 32'(line_cnt), 3);
        end_line(16'h0000, 1);
        drain();
        chk("abort_end_line_cnt", 32'(line_cnt), 4);

        // Reset with 3 words buffered: none of them may reach the FIFO
        wfull = 1'b1;
        line_start = 1'b1; tick(); line_start = 1'b0; tick();
        pix_valid = 1'b1; pix_data = 16'h0777; tick(); pix_valid = 1'b0;
        chk("mid_busy", 32'(busy), 1);
        wrst = 1'b1; wfull = 1'b0;
        chk("mid_winc_rst", 32'(winc), 0);
        tick(); wrst = 1'b0;
        chk("mid_winc_rel", 32'(winc), 0);
        chk("mid_ovf", 32'(ovf), 0);
        chk("mid_drop", 32'(drop_cnt), 0);
        chk("mid_line", 32'(line_cnt), 0);
        chk("mid_busy_rst", 32'(busy), 0);
        tick();
        chk("mid_winc_after", 32'(winc), 0);
        start_line(16'h0000);
        end_line(16'h0000, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
